// File: rtl/conv2d_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv2d_pkg : shared types and engine constants for the job sched.  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package conv2d_pkg;

    typedef logic [15:0] T;

    localparam int R       = 3;
    localparam int H       = 32;
    localparam int RUN_CYC = R + H * H;

    typedef struct packed {
        T           wbase;
        T           fbase;
        T           obase;
        logic [3:0] tag;
    } job_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/conv2d_job_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv2d_job_fifo : DEPTH-entry synchronous FIFO of job descriptors. |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module conv2d_job_fifo
    import conv2d_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  job_t                     data_i,
    input  logic                     pop_i,
    output job_t                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    job_t            mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     count_q;
    logic            wr_en;
    logic            rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A pop frees the slot the simultaneous push lands in, so full does not block it.
    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv2d_job_sched : queues conv2d jobs, runs the engine once per   |
// | job, rebases engine addresses and reports completion by tag.       |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module conv2d_job_sched #(
    parameter int DEPTH   = 4,
    parameter int R       = 3,
    parameter int H       = 32,
    parameter int RUN_CYC = R + H * H
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [15:0]              job_wbase_i,
    input  logic [15:0]              job_fbase_i,
    input  logic [15:0]              job_obase_i,
    input  logic [3:0]               job_tag_i,
    output logic                     eng_start_o,
    output logic                     eng_rstn_o,
    input  logic [15:0]              eng_raddr_i,
    input  logic                     eng_addr_is_weight_i,
    input  logic [15:0]              eng_waddr_i,
    input  logic                     eng_wen_i,
    output logic [15:0]              mem_raddr_o,
    output logic [15:0]              mem_waddr_o,
    output logic                     mem_wen_o,
    input  logic                     abort_i,
    output logic                     done_valid_o,
    input  logic                     done_ready_i,
    output logic [3:0]               done_tag_o,
    output logic                     done_err_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);

    import conv2d_pkg::*;

    localparam int CW = $clog2(RUN_CYC + 1);

    sched_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    job_t            cur_q, cur_d;
    logic            done_valid_q, done_valid_d;
    logic [3:0]      done_tag_q, done_tag_d;
    logic            done_err_q, done_err_d;
    logic            eng_rstn_q, eng_rstn_d;

    job_t            head;
    job_t            new_job;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            done_set;
    logic            set_err;
    logic            running;

    // Ready is also masked by reset so nothing is accepted while the queue is held empty.
    assign job_ready_o = ~fifo_full & ~rst_i;
    assign push        = job_valid_i & job_ready_o;
    assign new_job     = {job_wbase_i, job_fbase_i, job_obase_i, job_tag_i};

    conv2d_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (new_job),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (q_count_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
            done_err_q   <= 1'b0;
            eng_rstn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            done_valid_q <= done_valid_d;
            done_tag_q   <= done_tag_d;
            done_err_q   <= done_err_d;
            eng_rstn_q   <= eng_rstn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        pop         = 1'b0;
        eng_start_o = 1'b0;
        done_set    = 1'b0;
        set_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && (!done_valid_q || done_ready_i)) begin
                    state_d = START;
                end
            end
            START: begin
                eng_start_o = 1'b1;
                pop         = 1'b1;
                cur_d       = head;
                cnt_d       = CW'(RUN_CYC - 1);
                state_d     = abort_i ? ABORT : RUN;
            end
            RUN: begin
                if (abort_i) begin
                    state_d = ABORT;
                end else if (cnt_q == '0) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ABORT: begin
                done_set = 1'b1;
                set_err  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new record overrides a consume in the same cycle.
        done_valid_d = done_valid_q;
        done_tag_d   = done_tag_q;
        done_err_d   = done_err_q;
        if (done_valid_q && done_ready_i) begin
            done_valid_d = 1'b0;
        end
        if (done_set) begin
            done_valid_d = 1'b1;
            done_tag_d   = cur_q.tag;
            done_err_d   = set_err;
        end

        // Registered so the engine reset lines up with the ABORT cycle.
        eng_rstn_d = (state_d != ABORT);
    end

    assign running     = (state_q == RUN);
    assign mem_raddr_o = running ? ((eng_addr_is_weight_i ? cur_q.wbase : cur_q.fbase) + eng_raddr_i) : '0;
    assign mem_waddr_o = running ? (cur_q.obase + eng_waddr_i) : '0;
    assign mem_wen_o   = running & eng_wen_i;

    assign eng_rstn_o   = eng_rstn_q;
    assign done_valid_o = done_valid_q;
    assign done_tag_o   = done_tag_q;
    assign done_err_o   = done_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv2d_job_sched : directed, table and random checks against a  |
// | queue/timestamp reference model of the job scheduler.              |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module tb_conv2d_job_sched;
    import conv2d_pkg::*;

    localparam int DEPTH = 4;
    localparam int RUNC  = 3 + 32 * 32;
    localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_ABORT = 3;

    logic        clk, rst_i, job_valid_i, job_ready_o;
    logic [15:0] job_wbase_i, job_fbase_i, job_obase_i;
    logic [3:0]  job_tag_i;
    logic        eng_start_o, eng_rstn_o;
    logic [15:0] eng_raddr_i, eng_waddr_i, mem_raddr_o, mem_waddr_o;
    logic        eng_addr_is_weight_i, eng_wen_i, mem_wen_o, abort_i;
    logic        done_valid_o, done_ready_i, done_err_o, busy_o;
    logic [3:0]  done_tag_o;
    logic [2:0]  q_count_o;

    conv2d_job_sched #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_wbase_i(job_wbase_i), .job_fbase_i(job_fbase_i),
        .job_obase_i(job_obase_i), .job_tag_i(job_tag_i),
        .eng_start_o(eng_start_o), .eng_rstn_o(eng_rstn_o),
        .eng_raddr_i(eng_raddr_i), .eng_addr_is_weight_i(eng_addr_is_weight_i),
        .eng_waddr_i(eng_waddr_i), .eng_wen_i(eng_wen_i),
        .mem_raddr_o(mem_raddr_o), .mem_waddr_o(mem_waddr_o), .mem_wen_o(mem_wen_o),
        .abort_i(abort_i),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_tag_o(done_tag_o), .done_err_o(done_err_o),
        .busy_o(busy_o), .q_count_o(q_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: pending jobs as a queue, the running job finishes at a cycle timestamp.
    job_t       jq[$];
    int         m_mode = M_IDLE;
    job_t       m_cur = '0;
    int         m_end = 0;
    bit         m_dv = 0;
    logic [3:0] m_tag = '0;
    bit         m_err = 0;
    bit         m_rstn = 0;
    bit         m_pushed = 0;

    typedef struct {
        logic        isw;
        logic [15:0] raddr;
        logic [15:0] waddr;
        logic        wen;
        logic [15:0] exp_r;
        logic [15:0] exp_w;
    } addr_vec_t;

    addr_vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        logic [15:0] er, ew;
        logic        ewen;
        logic        eready;
        er = '0; ew = '0; ewen = 1'b0;
        if (m_mode == M_RUN) begin
            er   = (eng_addr_is_weight_i ? m_cur.wbase : m_cur.fbase) + eng_raddr_i;
            ew   = m_cur.obase + eng_waddr_i;
            ewen = eng_wen_i;
        end
        eready = !rst_i && (jq.size() < DEPTH);
        chk("model_ctl",
            {job_ready_o, eng_start_o, eng_rstn_o, busy_o, done_valid_o, done_tag_o, done_err_o, q_count_o, mem_wen_o},
            {eready, m_mode == M_START, m_rstn, m_mode != M_IDLE, m_dv, m_tag, m_err, 3'(jq.size()), ewen});
        chk("model_addr", {mem_raddr_o, mem_waddr_o}, {er, ew});
    endtask

    task automatic model_update();
        bit   acc, fin, ferr, old_dv;
        int   nm;
        job_t nj;
        if (rst_i) begin
            jq.delete();
            m_mode = M_IDLE; m_dv = 0; m_tag = '0; m_err = 0; m_rstn = 0; m_pushed = 0;
            return;
        end
        acc = job_valid_i && (jq.size() < DEPTH);
        nj  = {job_wbase_i, job_fbase_i, job_obase_i, job_tag_i};
        fin = 0; ferr = 0; nm = m_mode;
        old_dv = m_dv;
        if (m_dv && done_ready_i) m_dv = 0;
        case (m_mode)
            M_IDLE:  if (jq.size() > 0 && (!old_dv || done_ready_i)) nm = M_START;
            M_START: begin
                if (jq.size() > 0) m_cur = jq.pop_front();
                m_end = cyc + RUNC;
                nm = abort_i ? M_ABORT : M_RUN;
            end
            M_RUN: begin
                if (abort_i) nm = M_ABORT;
                else if (cyc == m_end) begin fin = 1; nm = M_IDLE; end
            end
            default: begin fin = 1; ferr = 1; nm = M_IDLE; end
        endcase
        if (acc) jq.push_back(nj);
        m_pushed = acc;
        if (fin) begin m_dv = 1; m_tag = m_cur.tag; m_err = ferr; end
        m_rstn = (nm != M_ABORT);
        m_mode = nm;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_job(input logic [15:0] w, input logic [15:0] f, input logic [15:0] o, input logic [3:0] tag);
        job_valid_i = 1'b1;
        job_wbase_i = w; job_fbase_i = f; job_obase_i = o; job_tag_i = tag;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (m_pushed) break;
        end
        chk("push_accepted", m_pushed, 1);
        job_valid_i = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 6000; i++) begin
            if (eng_start_o === 1'b1) break;
            step();
        end
        chk("start_seen", eng_start_o, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (done_valid_o === 1'b1) break;
            step();
        end
        chk("done_seen", done_valid_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   s;
        int   got[$];
        logic prev_busy;

        vecs[0] = '{1'b0, 16'h0021, 16'h0021, 1'b1, 16'h0221, 16'h0821};
        vecs[1] = '{1'b1, 16'h0002, 16'h0000, 1'b0, 16'h0102, 16'h0800};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hF800, 1'b1, 16'h01FF, 16'h0000};
        vecs[3] = '{1'b1, 16'h1234, 16'h0001, 1'b1, 16'h1334, 16'h0801};

        rst_i = 1'b1; job_valid_i = 0; job_wbase_i = 0; job_fbase_i = 0; job_obase_i = 0; job_tag_i = 0;
        eng_raddr_i = 0; eng_addr_is_weight_i = 0; eng_waddr_i = 0; eng_wen_i = 0;
        abort_i = 0; done_ready_i = 0;
        @(posedge clk); #1;
        step(); step();
        chk("reset_outputs",
            {job_ready_o, eng_start_o, eng_rstn_o, mem_raddr_o, mem_waddr_o, mem_wen_o,
             done_valid_o, done_tag_o, done_err_o, busy_o, q_count_o}, 0);
        rst_i = 1'b0;
        step();
        chk("rstn_after_reset", {eng_rstn_o, job_ready_o}, 2'b11);

        // Single job latency, address rebasing, then a held done slot blocking the next job.
        push_job(16'h0100, 16'h0200, 16'h0800, 4'd5);
        chk("lat_cycle1_start", eng_start_o, 0);
        step();
        chk("lat_cycle2_start", eng_start_o, 1);
        s = cyc;
        step();
        for (int k = 0; k < 4; k++) begin
            eng_addr_is_weight_i = vecs[k].isw; eng_raddr_i = vecs[k].raddr;
            eng_waddr_i = vecs[k].waddr; eng_wen_i = vecs[k].wen;
            #1;
            chk("addr_table", {mem_raddr_o, mem_waddr_o, mem_wen_o}, {vecs[k].exp_r, vecs[k].exp_w, vecs[k].wen});
            step();
        end
        eng_addr_is_weight_i = 0; eng_raddr_i = 0; eng_waddr_i = 0; eng_wen_i = 0;
        wait_done();
        chk("done_latency", cyc - s, 1028);
        chk("done_tag_err", {done_tag_o, done_err_o}, {4'd5, 1'b0});
        eng_raddr_i = 16'h1234; eng_waddr_i = 16'h0042; eng_wen_i = 1'b1;
        #1;
        chk("idle_mem_zero", {mem_raddr_o, mem_waddr_o, mem_wen_o}, 0);

        push_job(16'hFFFF, 16'h0300, 16'h0400, 4'd6);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("held_slot", {eng_start_o, busy_o, done_valid_o, done_tag_o}, {1'b0, 1'b0, 1'b1, 4'd5});
        end
        done_ready_i = 1'b1;
        step();
        chk("start_after_consume", {eng_start_o, done_valid_o}, 2'b10);
        step();
        eng_addr_is_weight_i = 1'b1; eng_raddr_i = 16'h0002;
        #1;
        chk("wrap_raddr", mem_raddr_o, 16'h0001);

        // Reset mid-run drops the running and the queued job.
        push_job(16'h0001, 16'h0002, 16'h0003, 4'd7);
        for (int i = 0; i < 10; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("post_reset_state",
            {busy_o, eng_start_o, done_valid_o, q_count_o, eng_rstn_o, mem_raddr_o, mem_waddr_o, mem_wen_o}, 0);
        step();
        chk("rstn_back", eng_rstn_o, 1);
        for (int i = 0; i < 30; i++) step();
        chk("no_restart", {busy_o, done_valid_o, q_count_o}, 0);
        eng_addr_is_weight_i = 0; eng_raddr_i = 0; eng_waddr_i = 0; eng_wen_i = 0;

        // Fill the queue behind a running job; tags must come back in order.
        push_job(16'h1000, 16'h2000, 16'h3000, 4'd0);
        wait_start();
        for (int t = 1; t <= 4; t++) push_job(16'(t), 16'(t * 2), 16'(t * 3), 4'(t));
        chk("full_count", {job_ready_o, q_count_o}, {1'b0, 3'd4});
        prev_busy = busy_o;
        for (int i = 0; i < 8000 && got.size() < 5; i++) begin
            if (done_valid_o && done_ready_i) got.push_back(int'(done_tag_o));
            if (eng_start_o) chk("idle_before_start", prev_busy, 0);
            prev_busy = busy_o;
            step();
        end
        chk("tag_count", got.size(), 5);
        foreach (got[k]) chk("tag_order", got[k], k);

        // Abort at cnt=500, then the queued job runs normally.
        push_job(16'h0A00, 16'h0B00, 16'h0C00, 4'd9);
        wait_start();
        push_job(16'h0D00, 16'h0E00, 16'h0F00, 4'd10);
        for (int i = 0; i < 2000; i++) begin
            if (m_mode == M_RUN && (m_end - cyc) == 500) break;
            step();
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_state", {eng_rstn_o, busy_o}, 2'b01);
        step();
        chk("abort_done", {done_valid_o, done_tag_o, done_err_o, eng_rstn_o}, {1'b1, 4'd9, 1'b1, 1'b1});
        wait_start();
        step();
        wait_done();
        chk("after_abort_done", {done_tag_o, done_err_o}, {4'd10, 1'b0});

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            job_valid_i = ($urandom % 8) == 0;
            job_wbase_i = 16'($urandom); job_fbase_i = 16'($urandom);
            job_obase_i = 16'($urandom); job_tag_i = 4'($urandom);
            done_ready_i = ($urandom % 4) != 0;
            abort_i = busy_o && (($urandom % 500) == 0);
            eng_addr_is_weight_i = 1'($urandom);
            eng_raddr_i = 16'($urandom); eng_waddr_i = 16'($urandom); eng_wen_i = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
